mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int DAT_W = 32;

  // addr[17:16] value that marks a memory-mapped IO location
  localparam logic [1:0] IO_PREFIX_DEF = 2'b11;

  typedef enum logic [1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_W = 2'd2
  } len_e;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  // Index of the last byte of an access; the unused encoding 3 behaves as a word.
  function automatic logic [1:0] len_last(input logic [1:0] len);
    case (len_e'(len))
      LEN_B:   return 2'd0;
      LEN_H:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller shared by the instruction cache and the
// load/store buffer. One access is in flight at a time; requests arriving
// while busy are parked in per-client pending registers.
//
// state    | meaning
// MC_IDLE  | no access in flight, choose LSB first, then instruction fetch
// MC_READ  | issuing addresses and collecting bytes (RAM has 1-cycle latency)
// MC_WRITE | driving one byte per cycle, held while the IO buffer is full
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ic_en_i,
  input  logic [DAT_W-1:0] ic_pc_i,
  output logic             ic_en_o,
  output logic [DAT_W-1:0] ic_ins_o,
  input  logic             ls_en_i,
  input  logic             ls_wr_i,
  input  logic [1:0]       ls_len_i,
  input  logic [DAT_W-1:0] ls_addr_i,
  input  logic [DAT_W-1:0] ls_data_i,
  output logic             ls_en_o,
  output logic [DAT_W-1:0] ls_data_o,
  input  logic             br_flag,
  input  logic [7:0]       mem_din_i,
  output logic [7:0]       mem_dout_o,
  output logic [DAT_W-1:0] mem_a_o,
  output logic             mem_wr_o,
  input  logic             io_buffer_full_i
);

  mc_state_e state_q, state_d;

  logic             ic_pend, ls_pend;
  logic [DAT_W-1:0] ic_pc;
  logic             ls_wr;
  logic [1:0]       ls_len;
  logic [DAT_W-1:0] ls_addr, ls_data;

  logic             op_ic;
  logic [1:0]       op_last;
  logic [2:0]       cnt;
  logic [DAT_W-1:0] wdata, rbuf, rfull;

  logic             ls_req, ic_req, req_wr;
  logic [1:0]       req_len;
  logic [DAT_W-1:0] req_addr, req_data, req_pc;
  logic             stall;
  logic             take_ls, take_ic, rd_adv, rd_done, wr_adv, wr_done, abort;

  // A pulse arriving while idle is served on the same edge, so the request
  // fields come straight from the ports when the pulse is present.
  assign ls_req   = ls_pend | ls_en_i;
  assign req_wr   = ls_en_i ? ls_wr_i   : ls_wr;
  assign req_len  = ls_en_i ? ls_len_i  : ls_len;
  assign req_addr = ls_en_i ? ls_addr_i : ls_addr;
  assign req_data = ls_en_i ? ls_data_i : ls_data;
  assign ic_req   = (ic_pend | ic_en_i) & ~br_flag;
  assign req_pc   = ic_en_i ? ic_pc_i : ic_pc;

  assign stall    = (mem_a_o[17:16] == IO_PREFIX) & io_buffer_full_i;
  assign mem_wr_o = en & (state_q == MC_WRITE) & ~stall;

  // Read buffer with the byte arriving this cycle merged in at slot cnt-1.
  always_comb begin
    rfull = rbuf;
    rfull[{cnt[1:0] - 2'd1, 3'b000} +: 8] = mem_din_i;
  end

  // Next-state and per-edge action decode.
  always_comb begin
    state_d = state_q;
    take_ls = 1'b0;
    take_ic = 1'b0;
    rd_adv  = 1'b0;
    rd_done = 1'b0;
    wr_adv  = 1'b0;
    wr_done = 1'b0;
    abort   = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (ls_req) begin
          take_ls = 1'b1;
          state_d = req_wr ? MC_WRITE : MC_READ;
        end else if (ic_req) begin
          take_ic = 1'b1;
          state_d = MC_READ;
        end
      end
      MC_READ: begin
        if (op_ic && br_flag) begin
          abort   = 1'b1;
          state_d = MC_IDLE;
        end else if (cnt == {1'b0, op_last} + 3'd1) begin
          rd_done = 1'b1;
          state_d = MC_IDLE;
        end else begin
          rd_adv = 1'b1;
        end
      end
      MC_WRITE: begin
        if (!stall) begin
          if (cnt == {1'b0, op_last}) begin
            wr_done = 1'b1;
            state_d = MC_IDLE;
          end else begin
            wr_adv = 1'b1;
          end
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MC_IDLE;
    else if (en) state_q <= state_d;
  end

  // Request capture, byte sequencing and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_pend    <= 1'b0;
      ls_pend    <= 1'b0;
      ic_pc      <= '0;
      ls_wr      <= 1'b0;
      ls_len     <= '0;
      ls_addr    <= '0;
      ls_data    <= '0;
      op_ic      <= 1'b0;
      op_last    <= '0;
      cnt        <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      mem_a_o    <= '0;
      mem_dout_o <= '0;
      ic_en_o    <= 1'b0;
      ic_ins_o   <= '0;
      ls_en_o    <= 1'b0;
      ls_data_o  <= '0;
    end else if (en) begin
      ic_en_o <= 1'b0;
      ls_en_o <= 1'b0;

      if (ls_en_i) begin
        ls_wr   <= ls_wr_i;
        ls_len  <= ls_len_i;
        ls_addr <= ls_addr_i;
        ls_data <= ls_data_i;
      end
      if (ic_en_i) ic_pc <= ic_pc_i;

      if (take_ls)      ls_pend <= 1'b0;
      else if (ls_en_i) ls_pend <= 1'b1;

      // A flush also kills a fetch pulse sampled on the same edge.
      if (br_flag || take_ic) ic_pend <= 1'b0;
      else if (ic_en_i)       ic_pend <= 1'b1;

      if (take_ls) begin
        op_ic      <= 1'b0;
        op_last    <= len_last(req_len);
        cnt        <= '0;
        rbuf       <= '0;
        mem_a_o    <= req_addr;
        wdata      <= req_data;
        mem_dout_o <= req_data[7:0];
      end
      if (take_ic) begin
        op_ic   <= 1'b1;
        op_last <= 2'd3;
        cnt     <= '0;
        rbuf    <= '0;
        mem_a_o <= req_pc;
      end

      if (rd_adv) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) rbuf <= rfull;
        if (cnt < {1'b0, op_last}) mem_a_o <= mem_a_o + 32'd1;
      end
      if (rd_done) begin
        if (op_ic) begin
          ic_ins_o <= rfull;
          ic_en_o  <= 1'b1;
        end else begin
          ls_data_o <= rfull;
          ls_en_o   <= 1'b1;
        end
      end

      if (wr_adv) begin
        cnt        <= cnt + 3'd1;
        mem_a_o    <= mem_a_o + 32'd1;
        wdata      <= wdata >> 8;
        mem_dout_o <= wdata[15:8];
      end
      if (wr_done) ls_en_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a reference memory, expected-response
// queues and a per-cycle compare process on writes and response pulses.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        ic_en_i;
  logic [31:0] ic_pc_i;
  logic        ic_en_o;
  logic [31:0] ic_ins_o;
  logic        ls_en_i, ls_wr_i;
  logic [1:0]  ls_len_i;
  logic [31:0] ls_addr_i, ls_data_i;
  logic        ls_en_o;
  logic [31:0] ls_data_o;
  logic        br_flag;
  logic [7:0]  mem_din_i, mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic        io_buffer_full_i;

  logic        tb_we;
  logic [17:0] tb_wa;
  logic [7:0]  tb_wd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_ic[$];
  logic [31:0] exp_ls[$];
  logic [31:0] last_load;
  logic [7:0]  ram     [0:262143];
  logic [7:0]  ref_mem [0:262143];
  logic        prev_ic, prev_ls;
  wr_t         cw;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .ic_en_i(ic_en_i), .ic_pc_i(ic_pc_i), .ic_en_o(ic_en_o), .ic_ins_o(ic_ins_o),
    .ls_en_i(ls_en_i), .ls_wr_i(ls_wr_i), .ls_len_i(ls_len_i), .ls_addr_i(ls_addr_i),
    .ls_data_i(ls_data_i), .ls_en_o(ls_en_o), .ls_data_o(ls_data_o),
    .br_flag(br_flag), .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o), .io_buffer_full_i(io_buffer_full_i)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM with one cycle of registered read latency.
  always @(posedge clk) begin
    mem_din_i <= ram[mem_a_o[17:0]];
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (mem_wr_o) ram[mem_a_o[17:0]] <= mem_dout_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write and every response pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_ic = 1'b0;
      prev_ls = 1'b0;
    end else begin
      if (mem_wr_o) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          cw = exp_wr.pop_front();
          chk("write_addr", mem_a_o, cw.a);
          chk("write_byte", {24'd0, mem_dout_o}, {24'd0, cw.d});
        end
      end
      if (ic_en_o) begin
        chk("ic_single_pulse", 32'(prev_ic), 32'd0);
        chk("ic_expected", 32'(exp_ic.size() != 0), 32'd1);
        if (exp_ic.size() != 0) chk("ic_ins", ic_ins_o, exp_ic.pop_front());
      end
      if (ls_en_o) begin
        chk("ls_single_pulse", 32'(prev_ls), 32'd0);
        chk("ls_expected", 32'(exp_ls.size() != 0), 32'd1);
        if (exp_ls.size() != 0) chk("ls_data", ls_data_o, exp_ls.pop_front());
      end
      prev_ic = ic_en_o;
      prev_ls = ls_en_o;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    ref_mem[a] = d;
    tick();
    tb_we = 1'b0;
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    logic [31:0] p;
    for (int k = 0; k < n; k++) begin
      p = a + 32'(k);
      v = v | ({24'd0, ref_mem[p[17:0]]} << (8 * k));
    end
    return v;
  endfunction

  task automatic model_load(input logic [31:0] a, input logic [1:0] len);
    last_load = ref_read(a, nbytes(len));
    exp_ls.push_back(last_load);
  endtask

  task automatic model_store(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    wr_t w;
    for (int k = 0; k < nbytes(len); k++) begin
      w.a = a + 32'(k);
      w.d = d[8*k +: 8];
      exp_wr.push_back(w);
      ref_mem[w.a[17:0]] = w.d;
    end
    exp_ls.push_back(last_load);
  endtask

  task automatic ic_req(input logic [31:0] pc);
    ic_en_i = 1'b1; ic_pc_i = pc;
    tick();
    ic_en_i = 1'b0;
  endtask

  task automatic ls_req(input logic wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    ls_en_i = 1'b1; ls_wr_i = wr; ls_len_i = len; ls_addr_i = a; ls_data_i = d;
    tick();
    ls_en_i = 1'b0;
  endtask

  task automatic wait_resp(input bit ic, input int max, output int n);
    n = 0;
    while (!(ic ? ic_en_o : ls_en_o) && n < max) begin
      tick();
      n++;
    end
    chk(ic ? "ic_resp_seen" : "ls_resp_seen", 32'(ic ? ic_en_o : ls_en_o), 32'd1);
  endtask

  task automatic count_ic(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ic_en_o) n++;
    end
  endtask

  task automatic chk_zero;
    chk("rst_mem_a", mem_a_o, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr_o), 32'd0);
    chk("rst_ic_en", 32'(ic_en_o), 32'd0);
    chk("rst_ic_ins", ic_ins_o, 32'd0);
    chk("rst_ls_en", 32'(ls_en_o), 32'd0);
    chk("rst_ls_data", ls_data_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] sb [0:3];
    rst = 1'b1; en = 1'b1;
    ic_en_i = 1'b0; ic_pc_i = '0;
    ls_en_i = 1'b0; ls_wr_i = 1'b0; ls_len_i = '0; ls_addr_i = '0; ls_data_i = '0;
    br_flag = 1'b0; io_buffer_full_i = 1'b0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    last_load = '0;

    poke(18'h01000, 8'h13); poke(18'h01001, 8'h05);
    poke(18'h01002, 8'h10); poke(18'h01003, 8'h00);
    poke(18'h00000, 8'h93); poke(18'h00001, 8'h05);
    poke(18'h00002, 8'h10); poke(18'h00003, 8'h00);
    poke(18'h3FFFF, 8'h77);
    tick();
    chk_zero();
    rst = 1'b0;
    tick();

    // word fetch with exact address and response timing
    exp_ic.push_back(ref_read(32'h1000, 4));
    ic_req(32'h1000);
    for (int k = 0; k < 4; k++) begin
      chk("fetch_addr", mem_a_o, 32'h1000 + 32'(k));
      chk("fetch_no_wr", 32'(mem_wr_o), 32'd0);
      chk("fetch_no_resp_yet", 32'(ic_en_o), 32'd0);
      tick();
    end
    chk("fetch_edge4_quiet", 32'(ic_en_o), 32'd0);
    tick();
    chk("fetch_edge5_pulse", 32'(ic_en_o), 32'd1);
    chk("fetch_ins", ic_ins_o, 32'h00100513);
    tick();
    chk("fetch_pulse_ends", 32'(ic_en_o), 32'd0);

    // store word to a non-IO address: a full IO buffer must not stall it
    sb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_store(32'h2000, 2'd2, 32'hDEADBEEF);
    io_buffer_full_i = 1'b1;
    ls_req(1'b1, 2'd2, 32'h2000, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      chk("store_wr", 32'(mem_wr_o), 32'd1);
      chk("store_addr", mem_a_o, 32'h2000 + 32'(k));
      chk("store_byte", {24'd0, mem_dout_o}, {24'd0, sb[k]});
      chk("store_no_resp_yet", 32'(ls_en_o), 32'd0);
      tick();
    end
    chk("store_done_pulse", 32'(ls_en_o), 32'd1);
    chk("store_wr_off", 32'(mem_wr_o), 32'd0);
    io_buffer_full_i = 1'b0;
    tick();

    // simultaneous requests: LSB first, fetch on the edge after the LSB response
    model_load(32'h2002, 2'd0);
    exp_ic.push_back(ref_read(32'h0, 4));
    ic_en_i = 1'b1; ic_pc_i = 32'h0;
    ls_en_i = 1'b1; ls_wr_i = 1'b0; ls_len_i = 2'd0; ls_addr_i = 32'h2002;
    tick();
    ic_en_i = 1'b0; ls_en_i = 1'b0;
    chk("arb_ls_first_addr", mem_a_o, 32'h2002);
    tick();
    chk("arb_ls_edge1_quiet", 32'(ls_en_o), 32'd0);
    tick();
    chk("arb_ls_pulse", 32'(ls_en_o), 32'd1);
    chk("arb_ls_data", ls_data_o, 32'h000000AD);
    tick();
    chk("arb_ic_accept_addr", mem_a_o, 32'h0);
    wait_resp(1'b1, 10, n);
    chk("arb_ic_latency", 32'(n), 32'd5);
    chk("arb_ic_ins", ic_ins_o, 32'h00100593);
    tick();

    // flush three edges into a fetch: no response at all, then a clean refetch
    ic_req(32'h1000);
    tick(); tick();
    br_flag = 1'b1;
    tick();
    br_flag = 1'b0;
    count_ic(10, n);
    chk("flush_no_resp", 32'(n), 32'd0);
    exp_ic.push_back(ref_read(32'h1000, 4));
    ic_req(32'h1000);
    wait_resp(1'b1, 10, n);
    chk("refetch_latency", 32'(n), 32'd5);
    chk("refetch_ins", ic_ins_o, 32'h00100513);
    tick();

    // flush on the same edge as a fetch pulse while the LSB is served
    model_load(32'h2000, 2'd0);
    ic_en_i = 1'b1; ic_pc_i = 32'h1000; br_flag = 1'b1;
    ls_en_i = 1'b1; ls_wr_i = 1'b0; ls_len_i = 2'd0; ls_addr_i = 32'h2000;
    tick();
    ic_en_i = 1'b0; br_flag = 1'b0; ls_en_i = 1'b0;
    wait_resp(1'b0, 10, n);
    chk("flush_same_edge_ls_latency", 32'(n), 32'd2);
    chk("flush_same_edge_ls_data", ls_data_o, 32'h000000EF);
    count_ic(10, n);
    chk("flush_same_edge_no_ic", 32'(n), 32'd0);

    // IO byte store stalled for three cycles
    model_store(32'h30000, 2'd0, 32'h41);
    io_buffer_full_i = 1'b1;
    ls_req(1'b1, 2'd0, 32'h30000, 32'h41);
    chk("io_addr", mem_a_o, 32'h30000);
    chk("io_stall0", 32'(mem_wr_o), 32'd0);
    tick();
    chk("io_stall1", 32'(mem_wr_o), 32'd0);
    tick();
    chk("io_stall2", 32'(mem_wr_o), 32'd0);
    io_buffer_full_i = 1'b0;
    #1;
    chk("io_write_now", 32'(mem_wr_o), 32'd1);
    chk("io_write_byte", {24'd0, mem_dout_o}, 32'h41);
    chk("io_no_resp_yet", 32'(ls_en_o), 32'd0);
    tick();
    chk("io_resp", 32'(ls_en_o), 32'd1);
    chk("io_wr_off", 32'(mem_wr_o), 32'd0);
    tick();

    // global enable dropped mid-store freezes the sequence and gates the strobe
    model_store(32'h2010, 2'd2, 32'h11223344);
    ls_req(1'b1, 2'd2, 32'h2010, 32'h11223344);
    tick();
    chk("en_before_addr", mem_a_o, 32'h2011);
    en = 1'b0;
    #1;
    chk("en_low_wr_gated", 32'(mem_wr_o), 32'd0);
    tick(); tick();
    chk("en_low_addr_held", mem_a_o, 32'h2011);
    chk("en_low_no_resp", 32'(ls_en_o), 32'd0);
    en = 1'b1;
    #1;
    chk("en_back_wr", 32'(mem_wr_o), 32'd1);
    chk("en_back_byte", {24'd0, mem_dout_o}, 32'h33);
    wait_resp(1'b0, 10, n);
    chk("en_resp_latency", 32'(n), 32'd3);
    tick();

    // illegal length 3 behaves as a word load
    model_load(32'h1000, 2'd3);
    ls_req(1'b0, 2'd3, 32'h1000, 32'h0);
    wait_resp(1'b0, 10, n);
    chk("len3_latency", 32'(n), 32'd5);
    chk("len3_data", ls_data_o, 32'h00100513);
    tick();

    // address wrap at the top of the address space
    model_load(32'hFFFFFFFF, 2'd2);
    ls_req(1'b0, 2'd2, 32'hFFFFFFFF, 32'h0);
    chk("wrap_addr0", mem_a_o, 32'hFFFFFFFF);
    tick();
    chk("wrap_addr1", mem_a_o, 32'h0);
    wait_resp(1'b0, 10, n);
    chk("wrap_latency", 32'(n), 32'd4);
    chk("wrap_data", ls_data_o, 32'h10059377);
    tick();

    // reset in the middle of a word load
    ls_req(1'b0, 2'd2, 32'h1000, 32'h0);
    tick();
    rst = 1'b1;
    exp_wr.delete(); exp_ic.delete(); exp_ls.delete();
    last_load = '0;
    tick();
    chk_zero();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ls_en_o) n++;
    end
    chk("rst_abort_no_resp", 32'(n), 32'd0);
    model_load(32'h2001, 2'd1);
    ls_req(1'b0, 2'd1, 32'h2001, 32'h0);
    wait_resp(1'b0, 10, n);
    chk("post_rst_latency", 32'(n), 32'd3);
    chk("post_rst_data", ls_data_o, 32'h0000ADBE);
    tick(); tick();

    chk("drain_wr", 32'(exp_wr.size()), 32'd0);
    chk("drain_ic", 32'(exp_ic.size()), 32'd0);
    chk("drain_ls", 32'(exp_ls.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
